// File: rtl/pe_ctrl_pkg.sv
// Shared constants and types for the PE-row sequencer.
// Geometry of the 3x3 conv strip and SRAM address widths.
package pe_ctrl_pkg;

  localparam int NUM_PE    = 8;
  localparam int KH        = 3;
  localparam int KW        = 3;
  localparam int CH_WORDS  = 4;
  localparam int ROW_WORDS = KW * CH_WORDS;
  localparam int BEATS     = KH * KW * CH_WORDS;
  localparam int ROW_PITCH = 264;
  localparam int IAW       = 11;
  localparam int KAW       = 11;
  localparam int RD_LAT    = 1;
  localparam int CW        = 8;
  localparam int DRAIN_CYC = RD_LAT + NUM_PE - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/pe_skew_dly.sv
// W-bit, D-stage shift register with synchronous reset.
// Used to skew kernel reads and PE strobes down the row.
module pe_skew_dly #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q [D];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < D; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[D-1];

endmodule

// File: rtl/pe_row_seq.sv
// Read sequencer for one row of PEs running a 3x3 convolution.
// Issues ifmap/kernel reads and skewed valid/final strobes.
module pe_row_seq
  import pe_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IAW-1:0]        cfg_if_base,
  input  logic [KAW-1:0]        cfg_ker_base,
  input  logic [CW-1:0]         cfg_out_cols,
  input  logic                  hold,
  output logic [IAW-1:0]        if_addr,
  output logic                  if_rd_en,
  output logic [NUM_PE*KAW-1:0] ker_addr,
  output logic [NUM_PE-1:0]     ker_rd_en,
  output logic [NUM_PE-1:0]     pe_valid,
  output logic [NUM_PE-1:0]     pe_final,
  output logic                  busy,
  output logic                  done
);

  localparam logic [3:0]     W_LAST   = 4'(ROW_WORDS - 1);
  localparam logic [1:0]     R_LAST   = 2'(KH - 1);
  localparam logic [5:0]     B_LAST   = 6'(BEATS - 1);
  localparam logic [3:0]     D_LAST   = 4'(DRAIN_CYC - 1);
  localparam logic [IAW-1:0] ROW_STEP = IAW'(ROW_PITCH);
  localparam logic [IAW-1:0] COL_STEP = IAW'(CH_WORDS);

  seq_state_t     state_q, state_d;
  logic [CW-1:0]  cols_q, cols_d;
  logic [CW-1:0]  c_q, c_d;
  logic [IAW-1:0] colb_q, colb_d;
  logic [IAW-1:0] rowb_q, rowb_d;
  logic [KAW-1:0] kbase_q, kbase_d;
  logic [3:0]     w_q, w_d;
  logic [1:0]     r_q, r_d;
  logic [5:0]     b_q, b_d;
  logic [3:0]     dcnt_q, dcnt_d;

  logic           issue;
  logic           fin_d;
  logic [IAW-1:0] ia_d;
  logic [KAW-1:0] ka_d;

  logic           en_q;
  logic           fin_q;
  logic [IAW-1:0] ia_q;
  logic [KAW-1:0] ka_q;
  logic           done_q;

  // A launch issues beat 0 in the same cycle, from the raw config inputs.
  always_comb begin
    state_d = state_q;
    cols_d  = cols_q;
    c_d     = c_q;
    colb_d  = colb_q;
    rowb_d  = rowb_q;
    kbase_d = kbase_q;
    w_d     = w_q;
    r_d     = r_q;
    b_d     = b_q;
    dcnt_d  = dcnt_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cols_d  = cfg_out_cols;
          kbase_d = cfg_ker_base;
          colb_d  = cfg_if_base;
          rowb_d  = cfg_if_base;
          c_d     = '0;
          w_d     = '0;
          r_d     = '0;
          b_d     = '0;
          state_d = (cfg_out_cols == '0) ? DONE : RUN;
          issue   = (cfg_out_cols != '0) && !hold;
        end
      end
      RUN: issue = !hold;
      DRAIN: begin
        if (dcnt_q == D_LAST) state_d = DONE;
        else dcnt_d = dcnt_q + 4'd1;
      end
      DONE: state_d = IDLE;
    endcase

    ia_d  = rowb_d + IAW'(w_d);
    ka_d  = kbase_d + KAW'(b_d);
    fin_d = issue && (b_d == B_LAST);

    if (issue) begin
      b_d = b_d + 6'd1;
      if (w_d != W_LAST) begin
        w_d = w_d + 4'd1;
      end else begin
        w_d = '0;
        if (r_d != R_LAST) begin
          r_d    = r_d + 2'd1;
          rowb_d = rowb_d + ROW_STEP;
        end else begin
          r_d = '0;
          b_d = '0;
          if (c_d == cols_d - CW'(1)) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end else begin
            c_d    = c_d + CW'(1);
            colb_d = colb_d + COL_STEP;
            rowb_d = colb_d;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cols_q  <= '0;
      c_q     <= '0;
      colb_q  <= '0;
      rowb_q  <= '0;
      kbase_q <= '0;
      w_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      dcnt_q  <= '0;
      en_q    <= 1'b0;
      fin_q   <= 1'b0;
      ia_q    <= '0;
      ka_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cols_q  <= cols_d;
      c_q     <= c_d;
      colb_q  <= colb_d;
      rowb_q  <= rowb_d;
      kbase_q <= kbase_d;
      w_q     <= w_d;
      r_q     <= r_d;
      b_q     <= b_d;
      dcnt_q  <= dcnt_d;
      en_q    <= issue;
      fin_q   <= fin_d;
      done_q  <= (state_q == DONE);
      if (issue) begin
        ia_q <= ia_d;
        ka_q <= ka_d;
      end
    end
  end

  assign if_addr  = ia_q;
  assign if_rd_en = en_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  assign ker_addr[KAW-1:0] = ka_q;
  assign ker_rd_en[0]      = en_q;

  for (genvar p = 1; p < NUM_PE; p++) begin : g_ker
    pe_skew_dly #(.W(KAW + 1), .D(p)) u_dly (
      .clk   (clk),
      .reset (reset),
      .d_i   ({en_q, ka_q}),
      .q_o   ({ker_rd_en[p], ker_addr[p*KAW +: KAW]})
    );
  end

  // Strobes trail the read by RD_LAT, then one cycle per PE.
  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    pe_skew_dly #(.W(2), .D(RD_LAT + p)) u_dly (
      .clk   (clk),
      .reset (reset),
      .d_i   ({en_q, fin_q}),
      .q_o   ({pe_valid[p], pe_final[p]})
    );
  end

endmodule

// File: doc/pe_row_seq.md
Name: pe_row_seq

Overview:
- Sequencer for one row of NUM_PE pe_8e processing elements running a 3x3 convolution.
- Generates ifmap SRAM and per-PE kernel SRAM read addresses/enables for a strip of output columns.
- Drives per-PE valid_in/final_in, skewed one cycle per PE to match the systolic activation shift chain.
- Sits between the layer controller (start/config) and the PE row plus its ifmap/kernel SRAMs.

Parameters:
- NUM_PE, 8, PEs in the row (also the number of kernel SRAMs).
- KH, 3, kernel rows.
- KW, 3, kernel columns.
- CH_WORDS, 4, 64-bit words per pixel (input channels/8).
- ROW_PITCH, 264, ifmap SRAM words between consecutive input rows (66 cols x 4).
- IAW, 11, ifmap SRAM address width.
- KAW, 11, kernel SRAM address width.
- RD_LAT, 1, SRAM read latency in cycles.
- CW, 8, width of the out_cols count.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle launch pulse, honoured only in IDLE
- cfg_if_base  in  IAW  ifmap word address of the top-left pixel for output column 0
- cfg_ker_base  in  KAW  kernel address of beat 0, same for every PE
- cfg_out_cols  in  CW  output columns to compute (stride 1)
- hold  in  1  stall: freezes issue while high
- if_addr  out  IAW  ifmap SRAM address
- if_rd_en  out  1  ifmap SRAM read enable
- ker_addr  out  NUM_PE*KAW  flat per-PE kernel addresses; PE p in slice p
- ker_rd_en  out  NUM_PE  per-PE kernel read enable
- pe_valid  out  NUM_PE  valid_in to PE p
- pe_final  out  NUM_PE  final_in to PE p
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the strip is complete

Behaviour:
- Beats per output column: BEATS = KH*KW*CH_WORDS (36).
- Beat index b = r*KW*CH_WORDS + w, where r = 0..KH-1 and w = 0..KW*CH_WORDS-1.
- Ifmap address for column c, beat b: cfg_if_base + c*CH_WORDS + r*ROW_PITCH + w, modulo 2^IAW.
- Kernel address for beat b: cfg_ker_base + b, modulo 2^KAW.
- States:
  - IDLE: start -> latch cfg, c=0, b=0, go to RUN. If cfg_out_cols==0, go to DONE with no reads issued.
  - RUN: each cycle with hold==0, issue one beat (if_rd_en=1) and advance b, then c. After beat BEATS-1 of column out_cols-1, go to DRAIN. No bubble between columns. When hold==1: if_rd_en=0, counters frozen, but the skew chains keep shifting, so bubbles propagate.
  - DRAIN: wait RD_LAT+NUM_PE-1 cycles, ignoring hold, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Timing (all outputs registered):
  - start sampled at edge T: first if_rd_en at cycle T+1.
  - ker_rd_en[p] and ker_addr slice p equal if_rd_en and kernel address delayed p cycles.
  - pe_valid[0] equals if_rd_en delayed RD_LAT; pe_valid[p] equals pe_valid[0] delayed p.
  - pe_final follows the same skew and is set only on the valid beat b==BEATS-1 of each column.
  - pe_final is never set without pe_valid.
- Reset: all outputs and every skew-chain stage are 0, state is IDLE. Reset mid-RUN or mid-DRAIN aborts with no done pulse; the next start behaves as a fresh launch.
- Config is held in internal registers; input changes after start have no effect until the next start.

Decomposition:
- Package pe_ctrl_pkg holds:
  - constants NUM_PE, KH, KW, CH_WORDS, BEATS;
  - state enum seq_state_t {IDLE, RUN, DRAIN, DONE};
  - address-width localparams.
- Sub-module pe_skew_dly: parametric W-bit, D-stage shift register with synchronous reset. Instantiated to skew kernel address/enable and valid/final.

Test Plan:
- Single column: cfg_if_base=0, cfg_ker_base=0, cfg_out_cols=1, start at cycle 0 ->
  - if_addr 0..11, 264..275, 528..539 on cycles 1..36;
  - ker_addr[0] 0..35 on cycles 1..36;
  - pe_valid[0] high on cycles 2..37, pe_final[0] on cycle 37, pe_final[7] on cycle 44;
  - done on cycle 45.
- Two columns: cfg_out_cols=2, cfg_if_base=10 ->
  - second column if_addr starts at 14 on cycle 37 with no gap;
  - pe_final[0] on cycles 37 and 73;
  - ker_addr restarts at 0.
- Hold: hold high for cycles 5-7 of a single-column run ->
  - if_rd_en low for exactly those 3 cycles, address sequence unchanged;
  - pe_valid[3] shows a 3-cycle gap shifted by 1+3 cycles;
  - done delayed by 3 cycles (cycle 48).
- Zero columns: cfg_out_cols=0 -> no if_rd_en or ker_rd_en, done one cycle after DONE entry, busy high only in DONE.
- Reset mid-run: assert reset at cycle 20 ->
  - next cycle all outputs 0, no done;
  - a new start produces the full single-column sequence.
- Start during busy plus wrap: pulse start at cycle 10 while running -> ignored. With cfg_if_base=2040, IAW=11 -> if_addr wraps 2047 -> 0.
